// File: rtl/icon_bstage.sv
// -----------------------------------------------------------------------------
// icon_bstage -- backpressured butterfly stage of the ICON interconnect.
//
// NODES = INPUTS/2 independent 2x2 switch nodes. Node n owns input and output
// indices 2n and 2n+1. Input 2n+j is steered to output 2n+addr[STAGE_NUM] and
// lands in that output's FIFO. When both inputs of a node want the same
// output in the same cycle, a per-node round-robin pointer picks the winner.
// The loser is stalled through i_ready.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid & ready are both high. A producer holding valid high with ready low
// must keep its addr/data stable. Ready may depend on valid, never the
// reverse. i_ready never depends on o_ready, so there is no combinational
// path from the downstream stage back to the upstream stage.
//
// Optional feature macro: ICON_BSTAGE_STATS_EN adds per-node saturating
// conflict-cycle counters and the o_conflict_cnt port.
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid/i_ready  per-input handshake
//   i_addr, i_data   packed [INPUTS-1:0][ADDR_W-1:0] / [INPUTS-1:0][DATA_W-1:0]
//   o_valid/o_ready  per-output handshake, o_valid = FIFO non-empty
//   o_addr, o_data   FIFO head entry, zero while the FIFO is empty
//   o_conflict_cnt   packed [NODES-1:0][CNT_W-1:0] (ICON_BSTAGE_STATS_EN only)
// -----------------------------------------------------------------------------
module icon_bstage #(
    parameter int INPUTS    = 32,
    parameter int DATA_W    = 1,
    parameter int ADDR_W    = 9,
    parameter int STAGE_NUM = 0,
    parameter int DEPTH     = 2
`ifdef ICON_BSTAGE_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [INPUTS-1:0]          i_valid,
    output logic [INPUTS-1:0]          i_ready,
    input  logic [INPUTS*ADDR_W-1:0]   i_addr,
    input  logic [INPUTS*DATA_W-1:0]   i_data,
    output logic [INPUTS-1:0]          o_valid,
    input  logic [INPUTS-1:0]          o_ready,
    output logic [INPUTS*ADDR_W-1:0]   o_addr,
    output logic [INPUTS*DATA_W-1:0]   o_data
`ifdef ICON_BSTAGE_STATS_EN
    ,
    output logic [INPUTS/2*CNT_W-1:0]  o_conflict_cnt
`endif
);

    localparam int NODES = INPUTS / 2;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // FIFO storage and control, one FIFO per output
    logic [ADDR_W-1:0] mem_addr [INPUTS][DEPTH];
    logic [DATA_W-1:0] mem_data [INPUTS][DEPTH];
    logic [PW-1:0]     rd_ptr   [INPUTS];
    logic [PW-1:0]     wr_ptr   [INPUTS];
    logic [CW-1:0]     count    [INPUTS];

    // Round-robin pointer per node: in a conflict, input 2n+prio wins
    logic              prio     [NODES];

    logic              route_bit [INPUTS];
    logic              fifo_full [INPUTS];
    logic              accept    [INPUTS];
    logic              push      [INPUTS];
    logic              pop       [INPUTS];
    logic [ADDR_W-1:0] push_addr [INPUTS];
    logic [DATA_W-1:0] push_data [INPUTS];
    logic              conflict  [NODES];
    logic              prio_flip [NODES];

    // -------------------------------------------------------------------------
    // Routing, arbitration and ready generation
    // -------------------------------------------------------------------------
    always_comb begin
        i_ready = '0;
        for (int i = 0; i < INPUTS; i++) begin
            route_bit[i] = i_addr[i*ADDR_W + STAGE_NUM];
            // Full blocks a push even if the head pops this same cycle, which
            // keeps i_ready independent of o_ready.
            fifo_full[i] = (count[i] == FULL_CNT);
            pop[i]       = o_ready[i] && (count[i] != '0);
            accept[i]    = 1'b0;
            push[i]      = 1'b0;
            push_addr[i] = '0;
            push_data[i] = '0;
        end

        for (int n = 0; n < NODES; n++) begin
            conflict[n] = i_valid[2*n] && i_valid[2*n+1] &&
                          (route_bit[2*n] == route_bit[2*n+1]);
            for (int j = 0; j < 2; j++) begin
                i_ready[2*n+j] = !fifo_full[2*n + int'(route_bit[2*n+j])] &&
                                 (!conflict[n] || (int'(prio[n]) == j));
            end
        end

        for (int i = 0; i < INPUTS; i++) begin
            accept[i] = i_valid[i] && i_ready[i];
        end

        // At most one input of a node is accepted per output, because a
        // same-output pair is always a conflict with a single winner.
        for (int i = 0; i < INPUTS; i++) begin
            if (accept[i]) begin
                push[2*(i/2) + int'(route_bit[i])]      = 1'b1;
                push_addr[2*(i/2) + int'(route_bit[i])] = i_addr[i*ADDR_W +: ADDR_W];
                push_data[2*(i/2) + int'(route_bit[i])] = i_data[i*DATA_W +: DATA_W];
            end
        end

        // Pointer moves only when the winner actually gets through
        for (int n = 0; n < NODES; n++) begin
            prio_flip[n] = conflict[n] && accept[2*n + int'(prio[n])];
        end
    end

    // -------------------------------------------------------------------------
    // FIFO control and arbitration state
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int o = 0; o < INPUTS; o++) begin
                rd_ptr[o] <= '0;
                wr_ptr[o] <= '0;
                count[o]  <= '0;
            end
            for (int n = 0; n < NODES; n++) begin
                prio[n] <= 1'b0;
            end
        end else begin
            for (int o = 0; o < INPUTS; o++) begin
                if (push[o]) begin
                    wr_ptr[o] <= wr_ptr[o] + PW'(1);
                end
                if (pop[o]) begin
                    rd_ptr[o] <= rd_ptr[o] + PW'(1);
                end
                if (push[o] && !pop[o]) begin
                    count[o] <= count[o] + CW'(1);
                end else if (!push[o] && pop[o]) begin
                    count[o] <= count[o] - CW'(1);
                end
            end
            for (int n = 0; n < NODES; n++) begin
                if (prio_flip[n]) begin
                    prio[n] <= !prio[n];
                end
            end
        end
    end

    // Payload storage needs no reset: outputs are masked while a FIFO is empty
    always_ff @(posedge i_clk) begin
        for (int o = 0; o < INPUTS; o++) begin
            if (push[o]) begin
                mem_addr[o][wr_ptr[o]] <= push_addr[o];
                mem_data[o][wr_ptr[o]] <= push_data[o];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output view of each FIFO head
    // -------------------------------------------------------------------------
    always_comb begin
        o_valid = '0;
        o_addr  = '0;
        o_data  = '0;
        for (int o = 0; o < INPUTS; o++) begin
            o_valid[o] = (count[o] != '0);
            if (count[o] != '0) begin
                o_addr[o*ADDR_W +: ADDR_W] = mem_addr[o][rd_ptr[o]];
                o_data[o*DATA_W +: DATA_W] = mem_data[o][rd_ptr[o]];
            end
        end
    end

`ifdef ICON_BSTAGE_STATS_EN
    // -------------------------------------------------------------------------
    // Conflict statistics: the loser of a conflict is always stalled, so every
    // conflict cycle is a stall cycle. Counters saturate at all-ones.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] conflict_cnt [NODES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < NODES; n++) begin
                conflict_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NODES; n++) begin
                if (conflict[n] && (conflict_cnt[n] != {CNT_W{1'b1}})) begin
                    conflict_cnt[n] <= conflict_cnt[n] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_conflict_cnt = '0;
        for (int n = 0; n < NODES; n++) begin
            o_conflict_cnt[n*CNT_W +: CNT_W] = conflict_cnt[n];
        end
    end
`endif

endmodule

// File: tb/tb_icon_bstage.sv
// -----------------------------------------------------------------------------
// tb_icon_bstage -- self-checking bench for icon_bstage (4 inputs, 2 nodes).
// A reference model (FIFO occupancy from the expected queues, a round-robin
// pointer and conflict counters) predicts i_ready/o_valid every cycle; the
// expected queues hold packets until the DUT pops them.
// -----------------------------------------------------------------------------
module tb_icon_bstage;

    localparam int INPUTS    = 4;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int STAGE_NUM = 1;
    localparam int DEPTH     = 2;
    localparam int NODES     = INPUTS / 2;
    localparam int CNT_W     = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [INPUTS-1:0]         tb_valid;
    logic [INPUTS-1:0]         i_ready;
    logic [INPUTS*ADDR_W-1:0]  tb_addr;
    logic [INPUTS*DATA_W-1:0]  tb_data;
    logic [INPUTS-1:0]         o_valid;
    logic [INPUTS-1:0]         tb_ordy;
    logic [INPUTS*ADDR_W-1:0]  o_addr;
    logic [INPUTS*DATA_W-1:0]  o_data;
`ifdef ICON_BSTAGE_STATS_EN
    logic [NODES*CNT_W-1:0]    o_conflict_cnt;
`endif

    icon_bstage #(
        .INPUTS    (INPUTS),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .STAGE_NUM (STAGE_NUM),
        .DEPTH     (DEPTH)
`ifdef ICON_BSTAGE_STATS_EN
        ,
        .CNT_W     (CNT_W)
`endif
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (tb_valid),
        .i_ready        (i_ready),
        .i_addr         (tb_addr),
        .i_data         (tb_data),
        .o_valid        (o_valid),
        .o_ready        (tb_ordy),
        .o_addr         (o_addr),
        .o_data         (o_data)
`ifdef ICON_BSTAGE_STATS_EN
        ,
        .o_conflict_cnt (o_conflict_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q [INPUTS][$];
    logic                     prio_m [NODES];
    int                       cnt_m  [NODES];
    logic [INPUTS-1:0]        acc_m;
    int                       n_cmp = 0;
    int                       n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rbit(input int i);
        return tb_addr[i*ADDR_W + STAGE_NUM];
    endfunction

    task automatic set_pkt(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        tb_addr[i*ADDR_W +: ADDR_W] = a;
        tb_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_model();
        for (int o = 0; o < INPUTS; o++) exp_q[o].delete();
        for (int n = 0; n < NODES; n++) begin
            prio_m[n] = 1'b0;
            cnt_m[n]  = 0;
        end
        acc_m = '0;
    endtask

    // Called shortly after a falling edge with inputs already driven.
    // Predicts and checks this cycle, updates the model, advances one cycle.
    task automatic step();
        logic [INPUTS-1:0] rdy_m;
        logic [INPUTS-1:0] vld_m;
        logic              conf [NODES];
        logic [ADDR_W+DATA_W-1:0] front;
        #1;
        for (int o = 0; o < INPUTS; o++) vld_m[o] = (exp_q[o].size() != 0);
        for (int n = 0; n < NODES; n++) begin
            conf[n] = tb_valid[2*n] && tb_valid[2*n+1] && (rbit(2*n) == rbit(2*n+1));
            for (int j = 0; j < 2; j++) begin
                rdy_m[2*n+j] = (exp_q[2*n + int'(rbit(2*n+j))].size() < DEPTH) &&
                               (!conf[n] || (prio_m[n] == (j == 1)));
            end
        end
        check("i_ready", 32'(i_ready), 32'(rdy_m));
        check("o_valid", 32'(o_valid), 32'(vld_m));
`ifdef ICON_BSTAGE_STATS_EN
        for (int n = 0; n < NODES; n++)
            check($sformatf("conflict_cnt%0d", n), 32'(o_conflict_cnt[n*CNT_W +: CNT_W]), cnt_m[n]);
`endif
        for (int o = 0; o < INPUTS; o++) begin
            if (vld_m[o] && tb_ordy[o]) begin
                front = exp_q[o].pop_front();
                check($sformatf("o_pkt%0d", o),
                      32'({o_addr[o*ADDR_W +: ADDR_W], o_data[o*DATA_W +: DATA_W]}), 32'(front));
            end
        end
        acc_m = tb_valid & rdy_m;
        for (int i = 0; i < INPUTS; i++) begin
            if (acc_m[i])
                exp_q[2*(i/2) + int'(rbit(i))].push_back({tb_addr[i*ADDR_W +: ADDR_W],
                                                           tb_data[i*DATA_W +: DATA_W]});
        end
        for (int n = 0; n < NODES; n++) begin
            if (conf[n]) begin
                if (acc_m[2*n + int'(prio_m[n])]) prio_m[n] = !prio_m[n];
                if (cnt_m[n] < (1 << CNT_W) - 1) cnt_m[n]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        tb_valid = '0;
        tb_ordy  = '1;
        for (int k = 0; k < cycles; k++) step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        tb_valid = '0;
        tb_addr  = '0;
        tb_data  = '0;
        tb_ordy  = '1;
        clear_model();

        // Reset state
        #1;
        check("rst_o_valid", 32'(o_valid), 32'h0);
        check("rst_o_data", 32'(o_data), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_i_ready", 32'(i_ready), 32'hf);

        // Straight and cross routed together
        tb_valid = 4'b0011;
        set_pkt(0, 4'b0000, 8'hA5);
        set_pkt(1, 4'b0010, 8'h3C);
        step();
        check("sc_accept", 32'(acc_m), 32'h3);
        #1;
        check("sc_o_valid", 32'(o_valid), 32'h3);
        check("sc_data0", 32'(o_data[7:0]), 32'hA5);
        check("sc_data1", 32'(o_data[15:8]), 32'h3C);
        idle(3);

        // Round-robin conflict on output 1
        tb_valid = 4'b0011;
        set_pkt(0, 4'b0010, 8'h10);
        set_pkt(1, 4'b0110, 8'h20);
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_grant%0d", k), 32'(i_ready[1:0]), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            if (acc_m[0]) set_pkt(0, 4'b0010, 8'h10 + 8'(k));
            if (acc_m[1]) set_pkt(1, 4'b0110, 8'h20 + 8'(k));
        end
        idle(4);

        // Full FIFO on output 1
        tb_ordy  = 4'b1101;
        tb_valid = 4'b0001;
        set_pkt(0, 4'b1010, 8'hD0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("full_rdy%0d", k), 32'(i_ready[0]), (k < 2) ? 32'h1 : 32'h0);
            step();
            if (acc_m[0]) set_pkt(0, 4'b1010, 8'hD1 + 8'(k));
        end
        #1;
        check("full_o_valid1", 32'(o_valid[1]), 32'h1);
        check("full_head", 32'(o_data[15:8]), 32'hD0);

        // Pop while full: slot frees only from the next cycle
        tb_ordy[1] = 1'b1;
        #1;
        check("popfull_rdy", 32'(i_ready[0]), 32'h0);
        step();
        tb_ordy[1] = 1'b0;
        #1;
        check("popfull_next_rdy", 32'(i_ready[0]), 32'h1);
        step();
        idle(4);

        // Random traffic with a mid-traffic reset
        for (int c = 0; c < 300; c++) begin
            if (c == 150) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("midrst_o_valid", 32'(o_valid), 32'h0);
                check("midrst_o_addr", 32'(o_addr), 32'h0);
                check("midrst_o_data", 32'(o_data), 32'h0);
                clear_model();
                tb_valid = '0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("midrst_i_ready", 32'(i_ready), 32'hf);
            end
            for (int o = 0; o < INPUTS; o++) tb_ordy[o] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < INPUTS; i++) begin
                if (acc_m[i] || !tb_valid[i]) begin
                    tb_valid[i] = ($urandom_range(0, 2) != 0);
                    set_pkt(i, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                end
            end
            step();
        end
        idle(6);

`ifdef ICON_BSTAGE_STATS_EN
        // Saturation: 20 conflict-stall cycles on node 0
        tb_ordy  = '0;
        tb_valid = 4'b0011;
        set_pkt(0, 4'b0010, 8'h71);
        set_pkt(1, 4'b0010, 8'h72);
        for (int k = 0; k < 20; k++) begin
            step();
            if (acc_m[0]) set_pkt(0, 4'b0010, 8'h80 + 8'(k));
            if (acc_m[1]) set_pkt(1, 4'b0010, 8'h90 + 8'(k));
        end
        #1;
        check("sat_cnt0", 32'(o_conflict_cnt[CNT_W-1:0]), 32'd15);
        idle(5);
        #1;
        check("sat_hold0", 32'(o_conflict_cnt[CNT_W-1:0]), 32'd15);
`endif

        for (int o = 0; o < INPUTS; o++)
            check($sformatf("drained%0d", o), 32'(exp_q[o].size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
